// File: rtl/lbrot_iter.sv
// lbrot_iter: multi-cycle left rotator, one shift-amount bit resolved per clock
// behind valid/ready handshakes on both sides.
module lbrot_iter #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           data_in_i,
  input  logic [$clog2(WIDTH)-1:0]   shift_amt_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           data_out_o,
  output logic                       busy_o
);
  localparam int LOG2 = $clog2(WIDTH);
  localparam logic [LOG2-1:0] LAST = LOG2'(LOG2 - 1);
  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("lbrot_iter: WIDTH must be a power of two and >= 2");
  end
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t             state_q;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [LOG2-1:0]    amt_q, cnt_q;
  logic               in_ready_q, out_valid_q, busy_q;
  logic [2*WIDTH-1:0] dbl;
  // amt_q is consumed LSB-first, so amt_q[0] always holds the bit for stage cnt_q
  always_comb begin
    dbl    = {data_q, data_q} << (1 << cnt_q);
    data_d = amt_q[0] ? dbl[2*WIDTH-1:WIDTH] : data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      amt_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid_i) begin
          data_q     <= data_in_i;
          amt_q      <= shift_amt_i;
          cnt_q      <= '0;
          state_q    <= SHIFT;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
        end
        SHIFT: begin
          data_q <= data_d;
          amt_q  <= amt_q >> 1;
          cnt_q  <= cnt_q + LOG2'(1);
          if (cnt_q == LAST) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: if (out_ready_i) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign data_out_o  = data_q;
endmodule

// File: tb/tb_lbrot_iter.sv
// tb_lbrot_iter: directed vector table and stall/reset sequences on an 8-bit
// instance, plus a randomized scoreboard run on a 32-bit instance.
module tb_lbrot_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic       iv8 = 0, or8 = 0, ir8, ov8, b8;
  logic [7:0] d8 = '0, q8;
  logic [2:0] a8 = '0;
  logic        iv32 = 0, or32 = 0, ir32, ov32, b32;
  logic [31:0] d32 = '0, q32;
  logic [4:0]  a32 = '0;

  lbrot_iter #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(iv8), .in_ready_o(ir8),
    .data_in_i(d8), .shift_amt_i(a8), .out_valid_o(ov8), .out_ready_i(or8),
    .data_out_o(q8), .busy_o(b8));
  lbrot_iter #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(iv32), .in_ready_o(ir32),
    .data_in_i(d32), .shift_amt_i(a32), .out_valid_o(ov32), .out_ready_i(or32),
    .data_out_o(q32), .busy_o(b32));

  typedef struct { logic [7:0] d; logic [2:0] a; logic [7:0] e; } vec_t;
  typedef struct { logic [31:0] e; int c; } sb_t;
  vec_t       tbl[8];
  logic [7:0] sb8[$];
  sb_t        sb32[$];
  int tests = 0, fails = 0;
  localparam int N32 = 1000;
  localparam int LIMIT = 60000;

  task automatic chk(input string n, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rol32(input logic [31:0] x, input int a);
    return (x << a) | (x >> (32 - a));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op8(input logic [7:0] d, input logic [2:0] a, input logic [7:0] e);
    int n;
    iv8 = 1; d8 = d; a8 = a; or8 = 1;
    n = 0;
    while (!ir8 && n < 50) begin tick(); n++; end
    sb8.push_back(e);
    tick();
    iv8 = 0;
    chk("busy_after_accept", b8, 1);
    chk("in_ready_after_accept", ir8, 0);
    n = 0;
    while (!ov8 && n < 20) begin tick(); n++; end
    chk("latency8", n, 3);
    chk("data8", q8, sb8.pop_front());
    tick();
    chk("out_valid_after_drain", ov8, 0);
    chk("in_ready_after_drain", ir8, 1);
    chk("busy_after_drain", b8, 0);
  endtask

  initial begin
    int n, seen;
    tbl[0] = '{8'hB4, 3'd3, 8'hA5};
    tbl[1] = '{8'h81, 3'd1, 8'h03};
    tbl[2] = '{8'h01, 3'd7, 8'h80};
    tbl[3] = '{8'h5A, 3'd0, 8'h5A};
    tbl[4] = '{8'h0F, 3'd4, 8'hF0};
    tbl[5] = '{8'hC3, 3'd5, 8'h78};
    tbl[6] = '{8'hFF, 3'd2, 8'hFF};
    tbl[7] = '{8'h80, 3'd1, 8'h01};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", ir8, 1);
    chk("rst_out_valid", ov8, 0);
    chk("rst_busy", b8, 0);
    chk("rst_data", q8, 0);
    rst_n = 1;
    tick();
    chk("post_rst_in_ready", ir8, 1);
    chk("post_rst_out_valid", ov8, 0);
    for (int i = 0; i < 8; i++) op8(tbl[i].d, tbl[i].a, tbl[i].e);

    // consumer stall with a pending producer
    iv8 = 1; d8 = 8'h0F; a8 = 3'd4; or8 = 0;
    sb8.push_back(8'hF0);
    tick();
    d8 = 8'h33; a8 = 3'd1;
    n = 0;
    while (!ov8 && n < 20) begin tick(); n++; end
    chk("stall_latency", n, 3);
    for (int i = 0; i < 10; i++) begin
      chk("stall_data", q8, sb8[0]);
      chk("stall_in_ready", ir8, 0);
      chk("stall_out_valid", ov8, 1);
      tick();
    end
    or8 = 1;
    sb8.push_back(8'h66);
    void'(sb8.pop_front());
    tick();
    chk("drain_out_valid", ov8, 0);
    chk("drain_in_ready", ir8, 1);
    tick();
    iv8 = 0;
    chk("second_accept_busy", b8, 1);
    n = 0;
    while (!ov8 && n < 20) begin tick(); n++; end
    chk("second_latency", n, 3);
    chk("second_data", q8, sb8.pop_front());
    tick();

    // reset during the second SHIFT cycle discards the operation
    iv8 = 1; d8 = 8'hC3; a8 = 3'd5;
    tick();
    iv8 = 0;
    tick();
    rst_n = 0;
    #1;
    chk("midrst_in_ready", ir8, 1);
    chk("midrst_out_valid", ov8, 0);
    chk("midrst_busy", b8, 0);
    chk("midrst_data", q8, 0);
    tick();
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (ov8) seen++; end
    chk("midrst_no_out_valid", seen, 0);
    op8(8'hC3, 3'd5, 8'h78);

    // randomized 32-bit run with consumer stalls
    fork
      begin
        for (int i = 0; i < N32 && cyc < LIMIT; i++) begin
          logic [31:0] d;
          int a;
          d = $urandom;
          a = $urandom_range(0, 31);
          iv32 = 1; d32 = d; a32 = 5'(a);
          while (!ir32 && cyc < LIMIT) tick();
          sb32.push_back('{rol32(d, a), cyc + 1});
          tick();
          iv32 = 0;
          if ($urandom_range(0, 3) == 0) tick();
        end
      end
      begin
        int got = 0;
        bit first = 1;
        while (got < N32 && cyc < LIMIT) begin
          or32 = ($urandom_range(0, 3) != 0);
          if (ov32) begin
            if (sb32.size() == 0) chk("sb32_empty", 1, 0);
            else begin
              if (first) begin
                chk("latency32", cyc - sb32[0].c, 5);
                chk("popcount32", $countones(q32), $countones(sb32[0].e));
                first = 0;
              end
              chk("data32", q32, sb32[0].e);
              if (or32) begin
                void'(sb32.pop_front());
                got++;
                first = 1;
              end
            end
          end
          tick();
        end
        chk("ops32_completed", got, N32);
      end
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lbrot_iter.md
Name: lbrot_iter

Overview:
- Iterative, multi-cycle left barrel rotator. It is the opposite-direction, sequential counterpart to the team's combinational right rotator.
- It resolves one shift-amount bit per clock, using a single variable-stage rotate datapath instead of a full log-depth mux tree.
- It sits between a producer and a consumer on valid/ready handshakes, for area-constrained datapaths that can tolerate latency.

Parameters:
- WIDTH, 8: data width in bits. Must be a power of two and >= 2; elaboration fails otherwise.
- LOG2 (localparam), $clog2(WIDTH): width of shift_amt and the number of iteration cycles.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer offers data_in/shift_amt.
- in_ready  output  1  block can accept an operation.
- data_in  input  WIDTH  word to rotate.
- shift_amt  input  LOG2  left-rotate amount, 0..WIDTH-1.
- out_valid  output  1  data_out holds a completed result.
- out_ready  input  1  consumer accepts the result.
- data_out  output  WIDTH  rotated word.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, busy=0, data_out=0, internal amt/count regs=0.
- Handshake rules:
  - An input transfer occurs on an edge where in_valid&&in_ready.
  - An output transfer occurs on an edge where out_valid&&out_ready.
  - in_ready is a pure function of state: it is 1 only in IDLE, with no combinational path from out_ready.
- Function: data_out = (data_in << shift_amt) | (data_in >> (WIDTH-shift_amt)), mod 2^WIDTH. For shift_amt=0 the result is data_in unchanged.
- FSM states IDLE, SHIFT, DONE:
  - IDLE: on an input transfer, latch data_in into the data reg, latch shift_amt into the amt reg, set cnt=0, go to SHIFT.
  - SHIFT: each edge, if amt[cnt]==1 then data reg <= data reg rotated left by (1<<cnt); otherwise hold. Then cnt++.
  - SHIFT exit: on the edge where cnt==LOG2-1 is processed, go to DONE and set out_valid=1.
  - DONE: out_valid=1 and data_out is stable. On an output transfer, go to IDLE and set out_valid=0. Otherwise hold indefinitely; data_out must not change while out_valid=1 and out_ready=0.
- Latency:
  - out_valid rises exactly LOG2 clock edges after the input-transfer edge, regardless of shift_amt; there is no early exit on zero bits.
  - Minimum issue interval is LOG2+2 cycles (accept, LOG2 shifts, drain, back in IDLE).
  - in_ready rises on the edge after the output transfer. Back-to-back accept in the drain cycle is not supported.
- data_out is driven from the data register at all times. Its value is only meaningful while out_valid=1.
- in_valid while not in IDLE is ignored. The producer must hold its data until in_ready; the block does not latch anything outside IDLE.
- out_ready while not in DONE is ignored.
- Reset mid-operation: rst_n low in SHIFT or DONE immediately returns all outputs to reset values. The in-flight operation is discarded, and no out_valid pulse occurs after release.
- WIDTH=2 (LOG2=1): a single SHIFT cycle, and the rotate by 1 is a swap.
- Rotate arithmetic is width-exact: no bits are lost, and the popcount of data_out equals the popcount of data_in.

Test Plan:
- WIDTH=8, reset asserted then released → in_ready=1, out_valid=0, busy=0, data_out=0x00.
- WIDTH=8, data_in=0xB4, shift_amt=3, out_ready=1 → out_valid rises exactly 3 edges after accept, data_out=0xA5, in_ready returns 1 the following cycle.
- WIDTH=8, sequence (0x81,1)→0x03, (0x01,7)→0x80, (0x5A,0)→0x5A → each completes with latency 3.
- WIDTH=8, (0x0F,4), out_ready held 0 for 10 cycles with in_valid=1 and a new data_in → data_out stays 0xF0, in_ready stays 0; releasing out_ready drains 0xF0 and the new input is accepted only afterwards.
- WIDTH=8, rst_n pulsed low during SHIFT cycle 2 of (0xC3,5) → outputs go to reset values immediately and no out_valid follows; a subsequent (0xC3,5) yields 0x78.
- WIDTH=32, random data/amount (≥1000 ops) with random out_ready stalls → every result matches the reference left-rotate model, latency is 5, and the popcount is preserved.
